// File: rtl/sfifo_fwft_rd_control.sv
//
// sfifo_fwft_rd_control
//   Read-side pointer controller for the synchronous FIFO. It sits across a
//   dual-port RAM with a 1-cycle registered read from the write controller.
//   RAM words are prefetched into a 2-entry output buffer. The consumer sees
//   first-word-fall-through data with a valid/ready handshake at one word per
//   cycle.
//
//   Optional build macro:
//     SFIFO_RD_LEVEL_EN - adds a registered RdLevel output. RdLevel counts the
//                         words in RAM, in flight and buffered.
//
`timescale 1ns/1ps

module sfifo_fwft_rd_control #(
    parameter int AddrLines = 8,
    parameter int DataWidth = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AddrLines:0]     SyncWrAddr,
    input  logic [DataWidth-1:0]   RamRdData,
    input  logic                   RdReady,
    output logic [AddrLines:0]     SyncRdAddr,
    output logic                   RdEn,
    output logic [AddrLines-1:0]   RdAddr,
    output logic [DataWidth-1:0]   RdData,
    output logic                   RdValid,
    output logic                   FIFOEmpty
`ifdef SFIFO_RD_LEVEL_EN
    ,
    output logic [AddrLines+1:0]   RdLevel
`endif
);

    // Output buffer: RdData is the head slot, skid is the second slot.
    logic [DataWidth-1:0] skid;
    logic [1:0]           buf_cnt;
    logic                 inflight;

    logic                 ram_empty;
    logic                 pop;
    logic [2:0]           occ_after_pop;
    logic [1:0]           cnt_after_pop;
    logic [1:0]           buf_cnt_nxt;
    logic [AddrLines:0]   rd_ptr_nxt;
    logic [DataWidth-1:0] head_nxt;
    logic [DataWidth-1:0] skid_nxt;

    assign ram_empty = (SyncRdAddr == SyncWrAddr);
    assign pop       = RdValid && RdReady;
    assign RdAddr    = SyncRdAddr[AddrLines-1:0];
    assign FIFOEmpty = ram_empty && !inflight && (buf_cnt == 2'd0);

    // Read issue decision and next-state values for the buffer.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        occ_after_pop = 3'd0;
        cnt_after_pop = 2'd0;
        buf_cnt_nxt   = 2'd0;
        RdEn          = 1'b0;
        rd_ptr_nxt    = SyncRdAddr;
        head_nxt      = RdData;
        skid_nxt      = skid;

        // pop implies buf_cnt >= 1, so the subtraction cannot underflow.
        occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        cnt_after_pop = buf_cnt - {1'b0, pop};
        buf_cnt_nxt   = cnt_after_pop + {1'b0, inflight};

        // NOTE: RdEn depends combinationally on RdReady. A pop in this cycle
        // frees a slot in time for the word that returns next cycle, and that
        // is what sustains one word per cycle.
        RdEn       = !ram_empty && (occ_after_pop < 3'd2);
        rd_ptr_nxt = SyncRdAddr + {{AddrLines{1'b0}}, RdEn};

        // A pop shifts skid into head, then returning RAM data fills the lowest
        // free slot. buf_cnt + inflight never exceeds 2, so a shift and a fill
        // never target the same slot.
        if (pop && (buf_cnt == 2'd2)) begin
            head_nxt = skid;
        end
        if (inflight) begin
            if (cnt_after_pop == 2'd0) begin
                head_nxt = RamRdData;
            end else begin
                skid_nxt = RamRdData;
            end
        end
    end

    // Read pointer advances on every issued RAM read.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            SyncRdAddr <= '0;
        end else begin
            SyncRdAddr <= rd_ptr_nxt;
        end
    end

    // inflight marks that RamRdData carries a valid word this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= RdEn;
        end
    end

    // Output buffer registers: head, skid, occupancy and the valid flag.
    // NOTE: the two data slots are ordinary flops, not a memory array, so they
    // are reset with the rest and RdData reads 0 right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RdData  <= '0;
            skid    <= '0;
            buf_cnt <= 2'd0;
            RdValid <= 1'b0;
        end else begin
            RdData  <= head_nxt;
            skid    <= skid_nxt;
            buf_cnt <= buf_cnt_nxt;
            RdValid <= (buf_cnt_nxt != 2'd0);
        end
    end

`ifdef SFIFO_RD_LEVEL_EN
    logic [AddrLines:0] ram_words_nxt;

    assign ram_words_nxt = SyncWrAddr - rd_ptr_nxt;

    // Total occupancy from next-state values: RAM words, in flight and buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RdLevel <= '0;
        end else begin
            RdLevel <= {1'b0, ram_words_nxt}
                     + {{(AddrLines+1){1'b0}}, RdEn}
                     + {{AddrLines{1'b0}}, buf_cnt_nxt};
        end
    end
`endif

endmodule
